// File: rtl/ast_rr_pkt_mux_pkg.sv
// Shared definitions for the round-robin packet mux: FSM states, channel-width
// helper and the registered output beat layout.
package ast_mux_pkg;

  localparam int BEAT_DATA_MAX_W = 512;
  localparam int BEAT_CH_MAX_W   = 6;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } mux_state_e;

  // Sized for the widest supported configuration; the top slices its own widths out.
  typedef struct packed {
    logic [BEAT_DATA_MAX_W-1:0] data;
    logic                       sop;
    logic                       eop;
    logic [BEAT_CH_MAX_W-1:0]   channel;
  } out_beat_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ast_rr_pkt_mux_rr_arb.sv
// Combinational round-robin arbiter: first request strictly after i_last_idx, wrapping.
// Double-width vector {req, req masked above last} so one low-to-high scan covers the wrap.
module rr_arb
  import ast_mux_pkg::*;
#(
  parameter int REQ_NUM = 32
) (
  input  logic [REQ_NUM-1:0]                  i_req,
  input  logic [clog2_min1(REQ_NUM)-1:0]      i_last_idx,
  output logic [clog2_min1(REQ_NUM)-1:0]      o_grant,
  output logic                                o_any_grant
);

  localparam int IDX_W = clog2_min1(REQ_NUM);

  logic [REQ_NUM-1:0]   w_mask;
  logic [2*REQ_NUM-1:0] w_dbl;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_mask[i] = (i > int'(i_last_idx));
    end
  end

  assign w_dbl = {i_req, i_req & w_mask};

  // Scanning downward lets the lowest set position win without a found flag.
  always_comb begin
    o_grant     = '0;
    o_any_grant = 1'b0;
    for (int i = 2*REQ_NUM-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        o_grant     = IDX_W'(i % REQ_NUM);
        o_any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ast_rr_pkt_mux.sv
// N-to-1 Avalon-ST round-robin mux, 1-cycle registered output, sink readies drop under backpressure.
// Packet locking is compiled in only when AST_RR_MUX_PKT_LOCK_EN is defined.
module ast_rr_pkt_mux
  import ast_mux_pkg::*;
#(
  parameter int IN_DIRS_CNT = 32,
  parameter int AST_SYMBOLS = 1,
  parameter int BYTE_W      = 8
) (
  input  logic                                              clk_i,
  input  logic                                              arst_i,
  input  logic [IN_DIRS_CNT-1:0][AST_SYMBOLS*BYTE_W-1:0]    ast_sink_data_i,
  input  logic [IN_DIRS_CNT-1:0]                            ast_sink_valid_i,
  input  logic [IN_DIRS_CNT-1:0]                            ast_sink_sop_i,
  input  logic [IN_DIRS_CNT-1:0]                            ast_sink_eop_i,
  output logic [IN_DIRS_CNT-1:0]                            ast_sink_ready_o,
  output logic [AST_SYMBOLS*BYTE_W-1:0]                     ast_source_data_o,
  output logic                                              ast_source_valid_o,
  output logic                                              ast_source_sop_o,
  output logic                                              ast_source_eop_o,
  output logic [clog2_min1(IN_DIRS_CNT)-1:0]                ast_source_channel_o,
  input  logic                                              ast_source_ready_i
);

  localparam int DATA_W = AST_SYMBOLS * BYTE_W;
  localparam int CH_W   = clog2_min1(IN_DIRS_CNT);

  logic                   w_pipe_rdy;
  logic                   w_accept;
  logic                   w_arb_any;
  logic                   w_any_grant;
  logic [CH_W-1:0]        w_arb_grant;
  logic [CH_W-1:0]        w_grant;
  logic [IN_DIRS_CNT-1:0] w_sink_rdy;
  logic [CH_W-1:0]        r_last_idx;
  logic                   r_src_vld;
  out_beat_t              r_beat;
  out_beat_t              w_beat_nxt;
  logic                   w_unused_pad;

  assign w_pipe_rdy = !r_src_vld || ast_source_ready_i;

  rr_arb #(
    .REQ_NUM    (IN_DIRS_CNT)
  ) u_rr_arb (
    .i_req      (ast_sink_valid_i),
    .i_last_idx (r_last_idx),
    .o_grant    (w_arb_grant),
    .o_any_grant(w_arb_any)
  );

`ifdef AST_RR_MUX_PKT_LOCK_EN
  mux_state_e      r_state;
  mux_state_e      w_state_nxt;
  logic [CH_W-1:0] r_lock_idx;
  logic [CH_W-1:0] w_lock_idx_nxt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= ST_ARB;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // A locked source keeps the grant even while idle; nothing preempts it.
  always_comb begin
    w_grant     = w_arb_grant;
    w_any_grant = w_arb_any;
    if (r_state == ST_LOCK) begin
      w_grant     = r_lock_idx;
      w_any_grant = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    case (r_state)
      ST_ARB: begin
        if (w_accept && !ast_sink_eop_i[w_grant]) begin
          w_state_nxt    = ST_LOCK;
          w_lock_idx_nxt = w_grant;
        end
      end
      ST_LOCK: begin
        if (w_accept && ast_sink_eop_i[w_grant]) begin
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end
`else
  assign w_grant     = w_arb_grant;
  assign w_any_grant = w_arb_any;
`endif

  assign w_accept = w_any_grant && w_pipe_rdy && ast_sink_valid_i[w_grant];

  always_comb begin
    w_sink_rdy = '0;
    if (w_any_grant && w_pipe_rdy && !arst_i) begin
      w_sink_rdy[w_grant] = 1'b1;
    end
  end

  assign ast_sink_ready_o = w_sink_rdy;

  always_comb begin
    w_beat_nxt         = '0;
    w_beat_nxt.data    = BEAT_DATA_MAX_W'(ast_sink_data_i[w_grant]);
    w_beat_nxt.sop     = ast_sink_sop_i[w_grant];
    w_beat_nxt.eop     = ast_sink_eop_i[w_grant];
    w_beat_nxt.channel = BEAT_CH_MAX_W'(w_grant);
  end

  // last_idx resets to the top input so input 0 is the first winner.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_src_vld  <= 1'b0;
      r_beat     <= '0;
      r_last_idx <= CH_W'(IN_DIRS_CNT - 1);
    end else if (w_accept) begin
      r_src_vld  <= 1'b1;
      r_beat     <= w_beat_nxt;
      r_last_idx <= w_grant;
    end else if (ast_source_ready_i) begin
      r_src_vld  <= 1'b0;
    end
  end

  assign ast_source_valid_o   = r_src_vld;
  assign ast_source_data_o    = r_beat.data[DATA_W-1:0];
  assign ast_source_sop_o     = r_beat.sop;
  assign ast_source_eop_o     = r_beat.eop;
  assign ast_source_channel_o = r_beat.channel[CH_W-1:0];

  assign w_unused_pad = ^{r_beat.data >> DATA_W, r_beat.channel >> CH_W};

endmodule

// File: tb/tb_ast_rr_pkt_mux.sv
// Bench for ast_rr_pkt_mux: per-input packet queues feed the DUT and a scoreboard
// built from the arbitration rules predicts readies and the ordered output beats.
module tb_ast_rr_pkt_mux;

  localparam int NIN = 32;
  localparam int DW  = 8;
`ifdef AST_RR_MUX_PKT_LOCK_EN
  localparam bit LOCK_MODE = 1'b1;
`else
  localparam bit LOCK_MODE = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [4:0]    ch;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     arst = 1'b1;
  logic [NIN-1:0][DW-1:0]   sink_data;
  logic [NIN-1:0]           sink_vld;
  logic [NIN-1:0]           sink_sop;
  logic [NIN-1:0]           sink_eop;
  logic [NIN-1:0]           sink_rdy;
  logic [DW-1:0]            src_data;
  logic                     src_vld;
  logic                     src_sop;
  logic                     src_eop;
  logic [4:0]               src_ch;
  logic                     src_rdy;

  always #5 clk = ~clk;

  ast_rr_pkt_mux #(
    .IN_DIRS_CNT(NIN),
    .AST_SYMBOLS(1),
    .BYTE_W     (DW)
  ) dut (
    .clk_i               (clk),
    .arst_i              (arst),
    .ast_sink_data_i     (sink_data),
    .ast_sink_valid_i    (sink_vld),
    .ast_sink_sop_i      (sink_sop),
    .ast_sink_eop_i      (sink_eop),
    .ast_sink_ready_o    (sink_rdy),
    .ast_source_data_o   (src_data),
    .ast_source_valid_o  (src_vld),
    .ast_source_sop_o    (src_sop),
    .ast_source_eop_o    (src_eop),
    .ast_source_channel_o(src_ch),
    .ast_source_ready_i  (src_rdy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t inq[NIN][$];
  beat_t sb[$];
  beat_t seen[$];
  int    seen_cyc[$];
  int    m_last;
  bit    m_locked;
  int    m_lock;
  int    rdy_mode;
  bit    gap_en;

  logic [NIN-1:0] exp_rdy, obs_rdy;
  logic           exp_vld, obs_vld;
  beat_t          exp_out, obs_out;

`define TICK_CHECKS(NAME) \
  checks++; \
  if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL %s sink_ready got=%h want=%h cyc=%0d", NAME, obs_rdy, exp_rdy, cyc); end \
  checks++; \
  if (obs_vld !== exp_vld) begin failures++; $display("FAIL %s source_valid got=%b want=%b cyc=%0d", NAME, obs_vld, exp_vld, cyc); end \
  if (exp_vld) begin \
    checks++; \
    if (obs_out !== exp_out) begin failures++; $display("FAIL %s source_beat got=%h want=%h cyc=%0d", NAME, obs_out, exp_out, cyc); end \
  end

`define DRAIN(NAME) \
  rdy_mode = 0; gap_en = 1'b0; \
  for (int c = 0; c < 400 && busy(); c++) begin tick(); `TICK_CHECKS(NAME) end \
  checks++; \
  if (busy()) begin failures++; $display("FAIL %s drain got=busy want=idle", NAME); end

  task automatic model_reset();
    for (int i = 0; i < NIN; i++) inq[i].delete();
    sb.delete();
    m_last   = NIN - 1;
    m_locked = 1'b0;
    m_lock   = 0;
  endtask

  task automatic push_pkt(input int src, input int len, input bit with_sop);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data = DW'($urandom);
      x.sop  = with_sop && (b == 0);
      x.eop  = (b == len - 1);
      x.ch   = 5'(src);
      inq[src].push_back(x);
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < NIN; i++) if (inq[i].size() != 0) return 1'b1;
    return sb.size() != 0;
  endfunction

  // Drive one cycle, predict readies/output from the rules, capture DUT, advance.
  task automatic tick();
    bit    v, src_r, any, pipe;
    int    g, k;
    beat_t b;
    for (int i = 0; i < NIN; i++) begin
      v = (inq[i].size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0));
      sink_vld[i] = v;
      if (v) begin
        sink_data[i] = inq[i][0].data;
        sink_sop[i]  = inq[i][0].sop;
        sink_eop[i]  = inq[i][0].eop;
      end else begin
        sink_data[i] = DW'($urandom);
        sink_sop[i]  = 1'($urandom_range(0, 1));
        sink_eop[i]  = 1'($urandom_range(0, 1));
      end
    end
    case (rdy_mode)
      0:       src_r = 1'b1;
      1:       src_r = 1'b0;
      default: src_r = 1'($urandom_range(0, 1));
    endcase
    src_rdy = src_r;
    #2;
    exp_vld = sb.size() > 0;
    exp_out = exp_vld ? sb[0] : '0;
    pipe    = !exp_vld || src_r;
    any     = 1'b0;
    g       = 0;
    if (LOCK_MODE && m_locked) begin
      any = 1'b1;
      g   = m_lock;
    end else begin
      for (int j = 1; j <= NIN; j++) begin
        k = (m_last + j) % NIN;
        if (!any && sink_vld[k]) begin
          any = 1'b1;
          g   = k;
        end
      end
    end
    exp_rdy = '0;
    if (any && pipe) exp_rdy[g] = 1'b1;
    obs_rdy = sink_rdy;
    obs_vld = src_vld;
    obs_out = {src_data, src_sop, src_eop, src_ch};
    if (exp_vld && src_r) begin
      seen.push_back(sb.pop_front());
      seen_cyc.push_back(cyc);
    end
    if (any && pipe && sink_vld[g]) begin
      b = inq[g].pop_front();
      sb.push_back(b);
      m_last = g;
      if (!m_locked && !b.eop) begin
        m_locked = 1'b1;
        m_lock   = g;
      end else if (m_locked && b.eop) begin
        m_locked = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; sink_vld = '0; sink_data = '0; sink_sop = '0; sink_eop = '0;
    src_rdy = 1'b1; rdy_mode = 0; gap_en = 1'b0;
    #2;
    checks++;
    if (src_vld !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", src_vld); end
    checks++;
    if ({src_data, src_sop, src_eop, src_ch} !== '0) begin
      failures++; $display("FAIL reset_fields got=%h want=0", {src_data, src_sop, src_eop, src_ch});
    end
    sink_vld = '1;
    #1;
    checks++;
    if (sink_rdy !== '0) begin failures++; $display("FAIL reset_ready got=%h want=0", sink_rdy); end
    @(posedge clk);
    #1;
    sink_vld = '0;
    arst = 1'b0;
    model_reset();
    tick();
    `TICK_CHECKS("reset_idle")
  endtask

  task automatic test_rr_single();
    int rr[3] = '{0, 3, 5};
    seen.delete(); seen_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 1, 1'b1); push_pkt(3, 1, 1'b1); push_pkt(5, 1, 1'b1);
    end
    `DRAIN("rr_single")
    checks++;
    if (seen.size() != 12) begin failures++; $display("FAIL rr_count got=%0d want=12", seen.size()); end
    for (int k = 0; k < seen.size(); k++) begin
      checks++;
      if (seen[k].ch !== 5'(rr[k % 3])) begin
        failures++; $display("FAIL rr_channel idx=%0d got=%0d want=%0d", k, seen[k].ch, rr[k % 3]);
      end
      if (k > 0) begin
        checks++;
        if (seen_cyc[k] != seen_cyc[k-1] + 1) begin
          failures++; $display("FAIL rr_bubble idx=%0d got_cycle=%0d want_cycle=%0d", k, seen_cyc[k], seen_cyc[k-1] + 1);
        end
      end
    end
  endtask

  task automatic test_lock();
    int exp_ch[8];
`ifdef AST_RR_MUX_PKT_LOCK_EN
    exp_ch = '{2, 2, 2, 2, 1, 1, 1, 1};
`else
    exp_ch = '{2, 1, 2, 1, 2, 1, 2, 1};
`endif
    seen.delete(); seen_cyc.delete();
    push_pkt(2, 4, 1'b1);
    tick();
    `TICK_CHECKS("lock")
    for (int k = 0; k < 4; k++) push_pkt(1, 1, 1'b1);
`ifdef AST_RR_MUX_PKT_LOCK_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      `TICK_CHECKS("lock")
      checks++;
      if (obs_rdy[1] !== 1'b0) begin failures++; $display("FAIL lock_holdoff got=%b want=0 cyc=%0d", obs_rdy[1], cyc); end
    end
`endif
    `DRAIN("lock")
    checks++;
    if (seen.size() != 8) begin failures++; $display("FAIL lock_count got=%0d want=8", seen.size()); end
    for (int k = 0; k < seen.size(); k++) begin
      checks++;
      if (seen[k].ch !== 5'(exp_ch[k])) begin
        failures++; $display("FAIL lock_channel idx=%0d got=%0d want=%0d", k, seen[k].ch, exp_ch[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t held;
    seen.delete(); seen_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      push_pkt(4, 1, 1'b1); push_pkt(9, 2, 1'b1); push_pkt(20, 1, 1'b1);
    end
    rdy_mode = 0;
    repeat (4) begin tick(); `TICK_CHECKS("bp_pre") end
    rdy_mode = 1;
    tick();
    `TICK_CHECKS("bp_stall")
    held = obs_out;
    checks++;
    if (obs_vld !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", obs_vld); end
    for (int k = 0; k < 4; k++) begin
      tick();
      `TICK_CHECKS("bp_stall")
      checks++;
      if (obs_vld !== 1'b1 || obs_out !== held) begin
        failures++; $display("FAIL bp_frozen got=%h/%b want=%h/1", obs_out, obs_vld, held);
      end
      checks++;
      if (obs_rdy !== '0) begin failures++; $display("FAIL bp_ready got=%h want=0", obs_rdy); end
    end
    `DRAIN("bp_release")
    checks++;
    if (seen.size() != 24) begin failures++; $display("FAIL bp_count got=%0d want=24", seen.size()); end
  endtask

  task automatic test_reset_mid_packet();
    seen.delete(); seen_cyc.delete();
    push_pkt(7, 6, 1'b1);
    repeat (3) begin tick(); `TICK_CHECKS("mid_rst_pre") end
    arst = 1'b1;
    #1;
    checks++;
    if (src_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", src_vld); end
    checks++;
    if (sink_rdy !== '0) begin failures++; $display("FAIL mid_rst_ready got=%h want=0", sink_rdy); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (src_vld !== 1'b0 || {src_data, src_sop, src_eop, src_ch} !== '0) begin
      failures++; $display("FAIL mid_rst_hold got=%b/%h want=0/0", src_vld, {src_data, src_sop, src_eop, src_ch});
    end
    arst = 1'b0;
    model_reset();
    seen.delete(); seen_cyc.delete();
    push_pkt(7, 3, 1'b0);
    push_pkt(0, 1, 1'b1);
    tick();
    `TICK_CHECKS("mid_rst_post")
    checks++;
    if (obs_rdy !== 32'h1) begin failures++; $display("FAIL mid_rst_grant got=%h want=00000001", obs_rdy); end
    `DRAIN("mid_rst_post")
    checks++;
    if (seen.size() != 4) begin
      failures++; $display("FAIL mid_rst_count got=%0d want=4", seen.size());
    end else begin
      checks++;
      if (seen[0].ch !== 5'd0) begin failures++; $display("FAIL mid_rst_first got=%0d want=0", seen[0].ch); end
    end
  endtask

  task automatic test_wrap();
    int exp_ch[3] = '{31, 0, 31};
    seen.delete(); seen_cyc.delete();
    push_pkt(31, 1, 1'b1);
    tick();
    `TICK_CHECKS("wrap")
    push_pkt(31, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    tick();
    `TICK_CHECKS("wrap")
    checks++;
    if (obs_rdy !== 32'h1) begin failures++; $display("FAIL wrap_grant got=%h want=00000001", obs_rdy); end
    `DRAIN("wrap")
    checks++;
    if (seen.size() != 3) begin failures++; $display("FAIL wrap_count got=%0d want=3", seen.size()); end
    for (int k = 0; k < seen.size(); k++) begin
      checks++;
      if (seen[k].ch !== 5'(exp_ch[k])) begin
        failures++; $display("FAIL wrap_channel idx=%0d got=%0d want=%0d", k, seen[k].ch, exp_ch[k]);
      end
    end
  endtask

  task automatic test_random();
    int total, s, l;
    total = 0;
    seen.delete(); seen_cyc.delete();
    rdy_mode = 2;
    gap_en   = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, NIN - 1);
        if (inq[s].size() < 8) begin
          l = $urandom_range(1, 4);
          push_pkt(s, l, 1'b1);
          total += l;
        end
      end
      tick();
      `TICK_CHECKS("random")
    end
    `DRAIN("random")
    checks++;
    if (seen.size() != total) begin failures++; $display("FAIL random_count got=%0d want=%0d", seen.size(), total); end
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
